// File: rtl/cl_serial_out_if.sv
// Request/status bundle between the register readback logic and the SerTFG transmitter.
interface cl_serial_out_if;
  logic       tx_req;
  logic [1:0] tx_rb;
  logic [7:0] tx_addr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_req, tx_rb, tx_addr, tx_data, input  tx_busy, tx_done);
  modport slave  (input  tx_req, tx_rb, tx_addr, tx_data, output tx_busy, tx_done);
endinterface

// File: rtl/cl_serial_out.sv
// Camera Link SerTFG UART transmitter: sends a bank/address/data triple as three
// 8N1 bytes, using the bit period measured by the SerTC receiver.
module cl_serial_out #(
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter logic [15:0] MIN_DIV     = 16'd3,
  parameter int          GAP_BITS    = 1
) (
  input  logic              clk_fix,
  input  logic              rst_fix,
  input  logic              lvds_swap,
  input  logic [15:0]       measured_baud,
  cl_serial_out_if.slave    tx,
  output logic              cl_sertfg_p,
  output logic              cl_sertfg_n
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  gap_q, gap_d;
  logic        line_q, line_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [1:0]  rb_q, rb_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  sh_q, sh_d;

  logic [15:0] eff_div;
  logic [7:0]  cur_byte;
  logic        last_clk;
  logic        byte_end;

  assign eff_div  = (measured_baud < MIN_DIV) ? DEFAULT_DIV : measured_baud;
  assign last_clk = (cnt_q == 16'd0);

  // Same packing as the host write protocol so one decoder serves both directions.
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = {addr_q[3:0], rb_q, 2'b01};
      2'd1:    cur_byte = {data_q[1:0], addr_q[7:4], 2'b11};
      default: cur_byte = {data_q[7:2], 2'b11};
    endcase
  end

  // State and control registers
  always_ff @(posedge clk_fix or posedge rst_fix) begin
    if (rst_fix) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame payload registers (only meaningful while busy)
  always_ff @(posedge clk_fix) begin
    rb_q   <= rb_d;
    addr_q <= addr_d;
    data_q <= data_d;
    div_q  <= div_d;
    sh_q   <= sh_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    gap_d    = gap_q;
    rb_d     = rb_q;
    addr_d   = addr_q;
    data_d   = data_q;
    div_d    = div_q;
    sh_d     = sh_q;
    byte_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx.tx_req) begin
          state_d = S_START;
          rb_d    = tx.tx_rb;
          addr_d  = tx.tx_addr;
          data_d  = tx.tx_data;
          div_d   = eff_div;
          cnt_d   = eff_div;
          byte_d  = 2'd0;
        end
      end
      S_START: begin
        if (last_clk) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = 3'd7;
          sh_d    = cur_byte;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (last_clk) begin
          cnt_d = div_q;
          if (bit_q == 3'd0) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q - 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (last_clk) begin
          if (GAP_BITS > 0) begin
            state_d = S_GAP;
            gap_d   = 2'(GAP_BITS - 1);
            cnt_d   = div_q;
          end else begin
            byte_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (last_clk) begin
          if (gap_q == 2'd0) begin
            byte_end = 1'b1;
          end else begin
            gap_d = gap_q - 2'd1;
            cnt_d = div_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_end) begin
      if (byte_q == 2'd2) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_START;
        byte_d  = byte_q + 2'd1;
        cnt_d   = div_q;
      end
    end
  end

  // Output logic: registered line value derived from the state being entered
  always_comb begin
    case (state_d)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = sh_d[0];
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  assign tx.tx_busy = busy_q;
  assign tx.tx_done = done_q;

  // The LVDS_33 OBUFDS pad pair is bound to this p/n pair at the IO ring.
  assign cl_sertfg_p = line_q ^ lvds_swap;
  assign cl_sertfg_n = ~(line_q ^ lvds_swap);

endmodule
